des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_pkg.sv | 48 ++++
 rtl/des_pc2_perm.sv | 17 +
 rtl/des_key_schedule.sv | 135 +++++++++++++
 tb/tb_des_key_schedule.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule tables (PC1, PC2, per-round shifts), helper functions and FSM state type.
package des_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // PC1: output bit i+1 takes FIPS key bit PC1_TAB[i]
  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC2: subkey bit j+1 takes C||D bit PC2_TAB[j]
  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_TAB [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic int cum_shift(input int n);
    int s;
    s = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= n) s += SHIFT_TAB[i];
    end
    return s;
  endfunction

  // Shift amount of a runtime round number; zero outside 1..16
  function automatic int shift_at(input logic [4:0] r);
    int s;
    s = 0;
    for (int i = 1; i <= 16; i++) begin
      if (r == 5'(i)) s = SHIFT_TAB[i];
    end
    return s;
  endfunction

  // Vector MSB is FIPS bit 1, so a FIPS left rotation is a vector left rotation
  function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
    return (x << s) | (x >> (28 - s));
  endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// PC2 compression: 56-bit C||D to 48-bit subkey, purely combinational.
module des_pc2_perm
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign subkey[47 - gi] = cd[56 - PC2_TAB[gi]];
  end

  // PC2 drops C||D bits 9, 18, 22, 25, 35, 38, 43 and 54
  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule streaming ROUNDS subkeys in encrypt or decrypt order.
// Define DES_KEY_PARITY_CHECK_EN to register an odd-parity check of each key byte.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        mode,
  input  logic        start_valid,
  output logic        start_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  round_idx,
  output logic        last,
  output logic        parity_err
);

  localparam logic [4:0] LAST_ENC = 5'(ROUNDS);
  localparam int         DEC_PRE  = cum_shift(ROUNDS) % 28;

  state_t      state_reg, state_next;
  logic [27:0] c_reg, c_next;
  logic [27:0] d_reg, d_next;
  logic [4:0]  round_reg, round_next;
  logic        mode_reg, mode_next;
  logic [55:0] pc1_cd;
  logic        start_fire;
  logic        advance;

  for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
    assign pc1_cd[55 - gi] = key_in[64 - PC1_TAB[gi]];
  end

  assign start_ready  = (state_reg == ST_IDLE) && !rst;
  assign subkey_valid = (state_reg == ST_RUN) && !rst;
  assign round_idx    = round_reg;
  assign last         = subkey_valid &&
                        (mode_reg ? (round_reg == 5'd1) : (round_reg == LAST_ENC));
  assign start_fire   = start_valid && start_ready;
  assign advance      = subkey_valid && subkey_ready;

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    round_next = round_reg;
    mode_next  = mode_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_fire) begin
          state_next = ST_RUN;
          mode_next  = mode;
          // Decrypt jumps straight to the last round's rotation
          if (mode) begin
            c_next     = rotl28(pc1_cd[55:28], DEC_PRE);
            d_next     = rotl28(pc1_cd[27:0], DEC_PRE);
            round_next = LAST_ENC;
          end else begin
            c_next     = rotl28(pc1_cd[55:28], SHIFT_TAB[1]);
            d_next     = rotl28(pc1_cd[27:0], SHIFT_TAB[1]);
            round_next = 5'd1;
          end
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (last) begin
            state_next = ST_IDLE;
          end else if (mode_reg) begin
            c_next     = rotl28(c_reg, 28 - shift_at(round_reg));
            d_next     = rotl28(d_reg, 28 - shift_at(round_reg));
            round_next = round_reg - 5'd1;
          end else begin
            c_next     = rotl28(c_reg, shift_at(round_reg + 5'd1));
            d_next     = rotl28(d_reg, shift_at(round_reg + 5'd1));
            round_next = round_reg + 5'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      round_reg <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      round_reg <= round_next;
      mode_reg  <= mode_next;
    end
  end

  des_pc2_perm u_pc2 (
    .cd     ({c_reg, d_reg}),
    .subkey (subkey)
  );

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] byte_even;
  logic       parity_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_par
    assign byte_even[gi] = ~^key_in[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (start_fire) begin
      parity_reg <= |byte_even;
    end
  end

  assign parity_err = parity_reg;
`else
  assign parity_err = 1'b0;

  // The eight parity bits of the key are not part of PC1
  logic unused_key_par;
  assign unused_key_par = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                            key_in[24], key_in[16], key_in[8], key_in[0]};
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer table, randomized schedules against a
// cumulative-shift reference model, and stall / reset corner sequences.
`timescale 1ns/1ps
module tb_des_key_schedule;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam int ROUNDS_OF [0:2] = '{16, 4, 1};

`ifdef DES_KEY_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT_T [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        mode;
  logic        subkey_ready;
  logic        start_valid   [0:2];
  logic        start_ready_w [0:2];
  logic [47:0] subkey_w      [0:2];
  logic        vld_w         [0:2];
  logic [4:0]  idx_w         [0:2];
  logic        last_w        [0:2];
  logic        perr_w        [0:2];

  int n_pass = 0;
  int n_total = 0;
  logic [47:0] got [1:16];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    des_key_schedule #(.ROUNDS(ROUNDS_OF[gi])) dut (
      .clk          (clk),
      .rst          (rst),
      .key_in       (key_in),
      .mode         (mode),
      .start_valid  (start_valid[gi]),
      .start_ready  (start_ready_w[gi]),
      .subkey       (subkey_w[gi]),
      .subkey_valid (vld_w[gi]),
      .subkey_ready (subkey_ready),
      .round_idx    (idx_w[gi]),
      .last         (last_w[gi]),
      .parity_err   (perr_w[gi])
    );
  end

  // Round r subkey straight from FIPS: C and D rotated left by the total shift of rounds 1..r
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
    logic cd0 [1:56];
    logic [47:0] k;
    int s;
    int p;
    int src;
    s = 0;
    for (int i = 1; i <= r; i++) s += SHIFT_T[i-1];
    for (int i = 1; i <= 56; i++) cd0[i] = key[64 - PC1_T[i-1]];
    for (int j = 1; j <= 48; j++) begin
      p = PC2_T[j-1];
      if (p <= 28) src = ((p - 1 + s) % 28) + 1;
      else         src = 28 + ((p - 29 + s) % 28) + 1;
      k[48-j] = cd0[src];
    end
    return k;
  endfunction

  function automatic logic exp_parity(input logic [63:0] k);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if ($countones(k[8*b +: 8]) % 2 == 0) e = 1'b1;
    end
    return e & PARITY_EN;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full schedule on DUT sel, every presented cycle checked against the model
  task automatic run_sched(input int sel, input logic [63:0] key, input bit m, input bit rand_ready);
    int n;
    int er;
    int fin;
    int cyc;
    bit done;
    n = ROUNDS_OF[sel];
    er = m ? n : 1;
    fin = m ? 1 : n;
    done = 1'b0;
    cyc = 0;
    while (start_ready_w[sel] !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("start_ready_pre", 64'(start_ready_w[sel]), 64'(1'b1));
    key_in = key;
    mode = m;
    start_valid[sel] = 1'b1;
    tick();
    start_valid[sel] = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      key_in = {$urandom, $urandom};
      mode = 1'($urandom_range(0, 1));
      subkey_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check("valid", 64'(vld_w[sel]), 64'(1'b1));
      check("round_idx", 64'(idx_w[sel]), 64'(er));
      check("subkey", 64'(subkey_w[sel]), 64'(ref_subkey(key, er)));
      check("last", 64'(last_w[sel]), 64'(er == fin));
      check("parity_err", 64'(perr_w[sel]), 64'(exp_parity(key)));
      got[er] = subkey_w[sel];
      if (subkey_ready) begin
        if (er == fin) done = 1'b1;
        else er = m ? er - 1 : er + 1;
      end
      tick();
      cyc++;
    end
    check("sched_complete", 64'(done), 64'(1'b1));
    subkey_ready = 1'b0;
    check("gap_valid", 64'(vld_w[sel]), 64'(1'b0));
    check("gap_start_ready", 64'(start_ready_w[sel]), 64'(1'b1));
    check("parity_hold", 64'(perr_w[sel]), 64'(exp_parity(key)));
    $display("schedule dut%0d key=%h mode=%0d cycles=%0d", sel, key, m, cyc);
  endtask

  typedef struct {
    int          sel;
    logic [63:0] key;
    bit          mode;
    int          r;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [0:9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1;
    key_in = '0;
    mode = 1'b0;
    subkey_ready = 1'b0;
    for (int i = 0; i < 3; i++) start_valid[i] = 1'b0;

    vecs[0] = '{0, KEY, 1'b0, 1,  48'h1B02EFFC7072};
    vecs[1] = '{0, KEY, 1'b0, 2,  48'h79AED9DBC9E5};
    vecs[2] = '{0, KEY, 1'b0, 4,  48'h72ADD6DB351D};
    vecs[3] = '{0, KEY, 1'b0, 16, 48'hCB3D8B0E17F5};
    vecs[4] = '{0, KEY, 1'b1, 16, 48'hCB3D8B0E17F5};
    vecs[5] = '{0, KEY, 1'b1, 1,  48'h1B02EFFC7072};
    vecs[6] = '{1, KEY, 1'b1, 4,  48'h72ADD6DB351D};
    vecs[7] = '{1, KEY, 1'b1, 1,  48'h1B02EFFC7072};
    vecs[8] = '{2, KEY, 1'b0, 1,  48'h1B02EFFC7072};
    vecs[9] = '{2, KEY, 1'b1, 1,  48'h1B02EFFC7072};

    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_start_ready", 64'(start_ready_w[i]), 64'(1'b0));
      check("rst_valid", 64'(vld_w[i]), 64'(1'b0));
      check("rst_subkey", 64'(subkey_w[i]), 64'(48'h0));
      check("rst_round_idx", 64'(idx_w[i]), 64'(5'd0));
      check("rst_last", 64'(last_w[i]), 64'(1'b0));
      check("rst_parity_err", 64'(perr_w[i]), 64'(1'b0));
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) check("post_rst_start_ready", 64'(start_ready_w[i]), 64'(1'b1));

    for (int v = 0; v < 10; v++) begin
      run_sched(vecs[v].sel, vecs[v].key, vecs[v].mode, 1'b0);
      check("kat_subkey", 64'(got[vecs[v].r]), 64'(vecs[v].exp));
    end

    // Stall three cycles on round 2, then drain
    key_in = KEY;
    mode = 1'b0;
    subkey_ready = 1'b1;
    start_valid[0] = 1'b1;
    tick();
    start_valid[0] = 1'b0;
    check("stall_k1", 64'(subkey_w[0]), 64'(48'h1B02EFFC7072));
    tick();
    subkey_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_k2", 64'(subkey_w[0]), 64'(48'h79AED9DBC9E5));
      check("stall_idx", 64'(idx_w[0]), 64'(5'd2));
      check("stall_last", 64'(last_w[0]), 64'(1'b0));
      tick();
    end
    subkey_ready = 1'b1;
    check("stall_k2_hs", 64'(subkey_w[0]), 64'(48'h79AED9DBC9E5));
    tick();
    check("after_stall_idx", 64'(idx_w[0]), 64'(5'd3));
    check("after_stall_k3", 64'(subkey_w[0]), 64'(ref_subkey(KEY, 3)));
    g = 0;
    while (!(vld_w[0] && last_w[0]) && g < 30) begin
      tick();
      g++;
    end
    tick();
    check("stall_drain_idle", 64'(start_ready_w[0]), 64'(1'b1));

    // Reset pulse during round 5
    key_in = KEY;
    mode = 1'b0;
    subkey_ready = 1'b1;
    start_valid[0] = 1'b1;
    tick();
    start_valid[0] = 1'b0;
    repeat (4) tick();
    check("pre_rst_idx", 64'(idx_w[0]), 64'(5'd5));
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(vld_w[0]), 64'(1'b0));
    check("midrst_start_ready", 64'(start_ready_w[0]), 64'(1'b0));
    check("midrst_round_idx", 64'(idx_w[0]), 64'(5'd0));
    rst = 1'b0;
    subkey_ready = 1'b0;
    tick();
    check("postrst_start_ready", 64'(start_ready_w[0]), 64'(1'b1));
    check("postrst_valid", 64'(vld_w[0]), 64'(1'b0));
    run_sched(0, KEY, 1'b0, 1'b0);
    check("postrst_k1", 64'(got[1]), 64'(48'h1B02EFFC7072));

    // Parity keys, then randomized keys, modes, DUTs and back-pressure
    run_sched(0, KEY, 1'b0, 1'b1);
    run_sched(0, 64'h123457799BBCDFF1, 1'b0, 1'b1);
    run_sched(1, 64'h123457799BBCDFF1, 1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      run_sched($urandom_range(0, 2), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
